// File: rtl/ysyx_22040895_li_expand_pkg.sv
// Shared constants, state/class encodings and RV64I encoders for the LI expander.
package ysyx_22040895_li_expand_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 12;
  localparam int unsigned HI_W  = 20;
  localparam int unsigned INS_W = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] F3_ADD    = 3'b000;

  typedef enum logic [1:0] {CLS_S12, CLS_S32, CLS_ERR} cls_e;
  typedef enum logic [1:0] {IDLE, EMIT_LUI, EMIT_ADDIW, EMIT_ADDI} state_e;

  function automatic logic [INS_W-1:0] enc_addi(input logic [IMM_W-1:0] imm,
                                                input logic [REG_W-1:0] rd);
    return {imm, 5'd0, F3_ADD, rd, OP_IMM};
  endfunction

  function automatic logic [INS_W-1:0] enc_lui(input logic [HI_W-1:0] hi,
                                               input logic [REG_W-1:0] rd);
    return {hi, rd, OP_LUI};
  endfunction

  function automatic logic [INS_W-1:0] enc_addiw(input logic [IMM_W-1:0] imm,
                                                 input logic [REG_W-1:0] rd);
    return {imm, rd, F3_ADD, rd, OP_IMM_32};
  endfunction

endpackage

// File: rtl/ysyx_22040895_li_split.sv
// Classifies a 64-bit constant by the instruction sequence it needs and splits it into LUI/ADDIW parts.
module ysyx_22040895_li_split
  import ysyx_22040895_li_expand_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] val,
  output cls_e            cls,
  output logic [19:0]     hi,
  output logic [11:0]     lo
);

  logic fits12;
  logic fits32;

  assign fits12 = (&val[63:11]) | ~(|val[63:11]);
  assign fits32 = (&val[63:31]) | ~(|val[63:31]);

  always_comb begin
    cls = CLS_ERR;
    if (fits12) begin
      cls = CLS_S12;
    end else if (fits32) begin
      cls = CLS_S32;
    end
  end

  // ADDIW sign-extends its immediate, so the upper part pre-compensates when bit 11 is set.
  assign hi = val[31:12] + {19'd0, val[11]};
  assign lo = val[11:0];

endmodule

// File: rtl/ysyx_22040895_li_expand.sv
// Expands a load-immediate request into a sequence of RV64I words (ADDI, or LUI with optional ADDIW).
module ysyx_22040895_li_expand
  import ysyx_22040895_li_expand_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] val_i,
  output logic            ins_valid_o,
  input  logic            ins_ready_i,
  output logic [ILEN-1:0] ins_o,
  output logic            last_o,
  output logic            err_o
);

  state_e      state;
  logic [4:0]  rd_q;
  logic [11:0] lo_q;

  cls_e        cls;
  logic [19:0] hi;
  logic [11:0] lo;

  ysyx_22040895_li_split #(
    .XLEN(XLEN)
  ) split (
    .val(val_i),
    .cls(cls),
    .hi (hi),
    .lo (lo)
  );

  assign req_ready_o = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state       <= IDLE;
      ins_valid_o <= 1'b0;
      ins_o       <= '0;
      last_o      <= 1'b0;
      err_o       <= 1'b0;
      rd_q        <= '0;
      lo_q        <= '0;
    end else begin
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            rd_q <= rd_i;
            lo_q <= lo;
            unique case (cls)
              CLS_S12: begin
                state       <= EMIT_ADDI;
                ins_valid_o <= 1'b1;
                ins_o       <= ILEN'(enc_addi(val_i[11:0], rd_i));
                last_o      <= 1'b1;
              end
              CLS_S32: begin
                state       <= EMIT_LUI;
                ins_valid_o <= 1'b1;
                ins_o       <= ILEN'(enc_lui(hi, rd_i));
                last_o      <= (lo == '0);
              end
              default: err_o <= 1'b1;
            endcase
          end
        end
        EMIT_LUI: begin
          if (ins_ready_i) begin
            if (lo_q == '0) begin
              state       <= IDLE;
              ins_valid_o <= 1'b0;
              ins_o       <= '0;
              last_o      <= 1'b0;
            end else begin
              state  <= EMIT_ADDIW;
              ins_o  <= ILEN'(enc_addiw(lo_q, rd_q));
              last_o <= 1'b1;
            end
          end
        end
        EMIT_ADDIW, EMIT_ADDI: begin
          if (ins_ready_i) begin
            state       <= IDLE;
            ins_valid_o <= 1'b0;
            ins_o       <= '0;
            last_o      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_li_expand.sv
// Randomized bench for the LI expander, checked every cycle against an arithmetic reference model.
module tb_ysyx_22040895_li_expand;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  rd = '0;
  logic [63:0] val = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins;
  logic        last;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } word_t;

  word_t exp_q[$];
  logic  err_pend = 1'b0;
  bit    armed = 1'b0;

  logic [63:0] edge_vals [10] = '{
    64'd2047, 64'hFFFF_FFFF_FFFF_F800, 64'd2048, 64'hFFFF_FFFF_FFFF_F7FF,
    64'h7FFF_FFFF, 64'h7FFF_F800, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
    64'hFFFF_FFFF_7FFF_FFFF, 64'h0
  };

  always #5 clk = ~clk;

  ysyx_22040895_li_expand #(
    .XLEN(64),
    .ILEN(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .rd_i       (rd),
    .val_i      (val),
    .ins_valid_o(ins_valid),
    .ins_ready_i(ins_ready),
    .ins_o      (ins),
    .last_o     (last),
    .err_o      (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: pick the shortest sequence by signed range, split as value = hi*4096 + signed lo.
  function automatic void expand(input logic [63:0] v, input logic [4:0] r,
                                 output bit e, output int n, output word_t w0, output word_t w1);
    longint sv;
    longint lim;
    longint lo_s;
    longint hi_s;
    sv  = v;
    lim = 64'sh8000_0000;
    e = 1'b0;
    n = 0;
    w0 = '0;
    w1 = '0;
    if (sv >= -2048 && sv <= 2047) begin
      n = 1;
      w0.w = 32'((sv & 64'hFFF) << 20) | (32'(r) << 7) | 32'h13;
      w0.l = 1'b1;
    end else if (sv >= -lim && sv < lim) begin
      lo_s = sv & 64'hFFF;
      if (lo_s >= 2048) lo_s = lo_s - 4096;
      hi_s = (sv - lo_s) >>> 12;
      w0.w = 32'((hi_s & 64'hFFFFF) << 12) | (32'(r) << 7) | 32'h37;
      if (lo_s == 0) begin
        n = 1;
        w0.l = 1'b1;
      end else begin
        n = 2;
        w0.l = 1'b0;
        w1.w = 32'((lo_s & 64'hFFF) << 20) | (32'(r) << 15) | (32'(r) << 7) | 32'h1B;
        w1.l = 1'b1;
      end
    end else begin
      e = 1'b1;
    end
  endfunction

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'(longint'(int'($urandom_range(0, 4095)) - 2048));
      1: v = 64'(longint'(int'($urandom())));
      2: v = 64'(longint'(int'($urandom() & 32'hFFFF_F000)));
      3: v = 64'(longint'(int'($urandom() | 32'h800)));
      4: v = {$urandom(), $urandom()};
      default: v = edge_vals[$urandom_range(0, 9)];
    endcase
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic [4:0] r);
    int unsigned waited;
    waited = 0;
    req_valid = 1'b1;
    val = v;
    rd = r;
    while (!req_ready && waited < 100) begin
      step(1);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout actual=%b required=1", req_ready);
    end
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic pin_model();
    bit e;
    int n;
    word_t w0, w1;
    expand(64'd5, 5'd10, e, n, w0, w1);
    check("pin_addi5", {w0.w, 31'(n), w0.l}, {32'h0050_0513, 31'd1, 1'b1});
    expand(64'hFFFF_FFFF_FFFF_FFFF, 5'd10, e, n, w0, w1);
    check("pin_addim1", {w0.w, 31'(n), w0.l}, {32'hFFF0_0513, 31'd1, 1'b1});
    expand(64'h1234_5000, 5'd1, e, n, w0, w1);
    check("pin_lui_only", {w0.w, 31'(n), w0.l}, {32'h1234_50B7, 31'd1, 1'b1});
    expand(64'h1234_5678, 5'd1, e, n, w0, w1);
    check("pin_lui_w0", {w0.w, 31'(n), w0.l}, {32'h1234_50B7, 31'd2, 1'b0});
    check("pin_addiw_w1", {w1.w, w1.l}, {32'h6780_809B, 1'b1});
    expand(64'h7FFF_F800, 5'd2, e, n, w0, w1);
    check("pin_wrap_w0", {w0.w, w0.l}, {32'h8000_0137, 1'b0});
    check("pin_wrap_w1", {w1.w, w1.l}, {32'h8001_011B, 1'b1});
    expand(64'h1_0000_0000, 5'd3, e, n, w0, w1);
    check("pin_err", 64'(e), 64'd1);
  endtask

  initial begin : monitor
    bit    e;
    int    n;
    word_t w0, w1;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("ins_valid", 64'(ins_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("ins_o", 64'(ins), 64'(exp_q[0].w));
          check("last", 64'(last), 64'(exp_q[0].l));
        end else begin
          check("ins_o_idle", 64'(ins), 64'd0);
        end
        check("err", 64'(err), 64'(err_pend));
        check("req_ready", 64'(req_ready), 64'(exp_q.size() == 0));
      end
      // advance the model across the coming rising edge
      if (rst) begin
        exp_q.delete();
        err_pend = 1'b0;
        armed = 1'b1;
      end else if (armed) begin
        err_pend = 1'b0;
        if (exp_q.size() != 0) begin
          if (ins_ready) void'(exp_q.pop_front());
        end else if (req_valid) begin
          expand(val, rd, e, n, w0, w1);
          if (e) begin
            err_pend = 1'b1;
          end else begin
            exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
          end
        end
      end
    end
  end

  initial begin : driver
    pin_model();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    ins_ready = 1'b1;
    step(1);

    send(64'd5, 5'd10);
    step(2);
    send(64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
    send(64'h1234_5000, 5'd1);
    send(64'h1234_5678, 5'd1);
    send(64'h7FFF_F800, 5'd2);
    send(64'h1_0000_0000, 5'd0);
    send(64'h1234_5678, 5'd0);
    step(3);

    ins_ready = 1'b0;
    send(64'h1234_5678, 5'd1);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ins_ready = 1'b1;
    step(4);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      rd        = 5'($urandom());
      val       = rand_val();
      ins_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    rst = 1'b0;
    req_valid = 1'b0;
    ins_ready = 1'b1;
    step(6);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_li_expand.md
YSYX_22040895_LI_EXPAND -- requirements
Module: ysyx_22040895_li_expand

Interface
REQ-001 SHALL have parameter XLEN, default 64, input constant width (only 64 supported).
REQ-002 SHALL have parameter ILEN, default 32, emitted instruction width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  block can accept request.
REQ-007 SHALL have port rd_i  input  5  destination register.
REQ-008 SHALL have port val_i  input  XLEN  constant to materialize.
REQ-009 SHALL have port ins_valid_o  output  1  instruction word valid.
REQ-010 SHALL have port ins_ready_i  input  1  consumer accepts word.
REQ-011 SHALL have port ins_o  output  ILEN  encoded RV64I instruction.
REQ-012 SHALL have port last_o  output  1  final word of sequence.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse: constant out of range.

Function
REQ-014 SHALL use FSM states IDLE, EMIT_LUI, EMIT_ADDIW, EMIT_ADDI; req_ready_o=1 only in IDLE.
REQ-015 SHALL accept a request on req_valid_i&&req_ready_o, latching rd_i and val_i.
REQ-016 SHALL classify at accept: S12 if val_i[63:11] all equal; else S32 if val_i[63:31] all equal; else ERR.
REQ-017 S12: SHALL go to EMIT_ADDI; word = {val[11:0],5'd0,3'b000,rd,7'b0010011}, last_o=1.
REQ-018 S32: hi = val[31:12] + val[11] modulo 2^20 (wrap); lo = val[11:0]; SHALL go to EMIT_LUI; word = {hi,rd,7'b0110111}.
REQ-019 EMIT_LUI: last_o=1 if lo==0, else 0; on handshake SHALL go to IDLE if lo==0, else EMIT_ADDIW.
REQ-020 EMIT_ADDIW: word = {lo,rd,3'b000,rd,7'b0011011}, last_o=1.
REQ-021 ERR: SHALL pulse err_o for exactly the cycle after accept, emit no word, stay in IDLE.
REQ-022 ins_o, ins_valid_o, last_o SHALL be registered; first word valid exactly 1 cycle after accept.
REQ-023 While ins_valid_o=1 and ins_ready_i=0, ins_o and last_o SHALL hold stable.
REQ-024 A word transfers on ins_valid_o&&ins_ready_i; the next word of the same sequence SHALL be valid the following cycle.
REQ-025 After the last handshake, FSM SHALL be in IDLE next cycle; no same-cycle accept of a new request.
REQ-026 ins_o SHALL be 0 whenever ins_valid_o=0.
REQ-027 rd=0 SHALL be encoded as given, no special case.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, ins_valid_o=0, ins_o=0, last_o=0, err_o=0.
REQ-029 req_ready_o SHALL be 1 in the cycle after reset is released.
REQ-030 Reset mid-sequence SHALL discard the sequence; no remaining word emitted.
REQ-031 Reset SHALL take priority over any handshake in the same cycle.

Structure
REQ-032 Opcodes (0010011, 0011011, 0110111), funct3 000, RstEnable and width macros SHALL live in the shared define include.
REQ-033 Classification and hi/lo split SHALL be one combinational sub-module, ysyx_22040895_li_split; FSM and output registers live in the top.

Verification
REQ-034 val=5, rd=10 -> one word 0x00500513, last=1; val=-1, rd=10 -> 0xFFF00513, last=1.
REQ-035 val=0x12345000, rd=1 -> one word 0x123450B7 with last=1; no ADDIW.
REQ-036 val=0x12345678, rd=1 -> 0x123450B7 (last=0), then 0x6780809B (last=1).
REQ-037 val=0x7FFFF800, rd=2 -> 0x80000137 (last=0), then 0x8001011B (last=1); checks hi wrap.
REQ-038 val=0x100000000 -> err_o high 1 cycle, ins_valid_o stays 0, req_ready_o=1 next cycle.
REQ-039 val=0x12345678, ins_ready_i low 5 cycles -> ins_o stable at 0x123450B7; assert rst -> ins_valid_o=0 next cycle, then req_ready_o=1, no ADDIW emitted.
